// File: rtl/conv_window_rd.sv
// Read-side sweep of the binary image buffer: issues column reads row by row and
// assembles the returned column slices into sliding KxK windows for the convolution MAC.
module conv_window_rd #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned K     = 5
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             cal_start,
  output logic [4:0]       data_rd_addr,
  output logic [4:0]       conv_row_cnt,
  input  logic [K-1:0]     col_data,
  output logic [K*K-1:0]   win_data,
  output logic             win_vld,
  output logic [4:0]       win_row,
  output logic [4:0]       win_col,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;

  localparam logic [4:0] LastCol    = 5'(IMG_W - 1);
  localparam logic [4:0] LastRow    = 5'(OUT_H - 1);
  localparam logic [4:0] FirstWin   = 5'(K - 1);
  localparam logic [4:0] LastWinCol = 5'(OUT_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StRowEnd, StDrain} state_e;

  state_e         state_q, state_d;
  logic [4:0]     addr_q, addr_d;
  logic [4:0]     row_q, row_d;
  logic           rd_vld_q;
  logic [4:0]     rd_col_q;
  logic [K*K-1:0] sr_q;
  logic [K*K-1:0] sr_shift;
  logic           win_cap;
  logic [K*K-1:0] win_data_q;
  logic           win_vld_q;
  logic [4:0]     win_row_q;
  logic [4:0]     win_col_q;
  logic           frame_done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (cal_start) begin
          state_d = StRun;
          addr_d  = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (addr_q == LastCol) state_d = StRowEnd;
        else                   addr_d  = addr_q + 5'd1;
      end
      // Row select held here so the last column's slice still belongs to this window row.
      StRowEnd: begin
        if (row_q < LastRow) begin
          state_d = StRun;
          row_d   = row_q + 5'd1;
          addr_d  = '0;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (frame_done_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Newest column enters at the top; column 0 of a row starts from an empty window.
  always_comb begin
    if (rd_col_q == 5'd0) sr_shift = {col_data, {(K*K-K){1'b0}}};
    else                  sr_shift = {col_data, sr_q[K*K-1:K]};
  end

  assign win_cap = rd_vld_q && (rd_col_q >= FirstWin);

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      row_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_col_q     <= '0;
      sr_q         <= '0;
      win_data_q   <= '0;
      win_vld_q    <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      rd_vld_q     <= (state_q == StRun);
      rd_col_q     <= addr_q;
      if (rd_vld_q) sr_q <= sr_shift;
      win_vld_q    <= win_cap;
      frame_done_q <= win_cap && (row_q == LastRow) && (rd_col_q - FirstWin == LastWinCol);
      if (win_cap) begin
        win_data_q <= sr_shift;
        win_col_q  <= rd_col_q - FirstWin;
        win_row_q  <= row_q;
      end
    end
  end

  assign data_rd_addr = addr_q;
  assign conv_row_cnt = row_q;
  assign win_data     = win_data_q;
  assign win_vld      = win_vld_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign busy         = (state_q != StIdle);
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_rd.sv
// Scoreboard bench for conv_window_rd: an image-buffer model answers reads, expected
// windows are queued per frame and a negedge monitor pops and compares each emitted window.
module tb_conv_window_rd;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic        cal_start;
  logic [4:0]  data_rd_addr;
  logic [4:0]  conv_row_cnt;
  logic [4:0]  col_data;
  logic [24:0] win_data;
  logic        win_vld;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        busy;
  logic        frame_done;

  always #5 sclk = ~sclk;

  conv_window_rd dut (
    .sclk         (sclk),
    .s_rst        (s_rst),
    .cal_start    (cal_start),
    .data_rd_addr (data_rd_addr),
    .conv_row_cnt (conv_row_cnt),
    .col_data     (col_data),
    .win_data     (win_data),
    .win_vld      (win_vld),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Image buffer model: one-cycle registered address, row select applied combinationally.
  bit         img [0:27][0:27];
  logic [4:0] buf_addr;
  always @(posedge sclk) buf_addr <= data_rd_addr;
  always_comb begin
    col_data = '0;
    for (int r = 0; r < 5; r++)
      if (int'(conv_row_cnt) + r < 28 && int'(buf_addr) < 28)
        col_data[r] = img[int'(conv_row_cnt) + r][buf_addr];
  end

  typedef struct packed {
    logic [4:0]  row;
    logic [4:0]  col;
    logic [24:0] data;
    logic        done;
  } win_t;

  win_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vld_cnt = 0;
  int          done_cnt = 0;
  int          bad23 = 0;
  int          gap = 0;
  logic [24:0] seen [0:2];
  logic [4:0]  prev_addr = '0;
  logic [4:0]  prev_row = '0;

  task automatic push_frame();
    win_t w;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) begin
        w.row  = 5'(r);
        w.col  = 5'(c);
        w.data = '0;
        for (int cc = 0; cc < 5; cc++)
          for (int rr = 0; rr < 5; rr++)
            w.data[5*cc+rr] = img[r+rr][c+cc];
        w.done = (r == 23) && (c == 23);
        exp_q.push_back(w);
      end
  endtask

  // Monitor: pops one expected window per win_vld.
  always @(negedge sclk) begin
    win_t e;
    if (win_vld) begin
      vld_cnt++;
      if (frame_done) done_cnt++;
      if (win_row == 5'd0 && win_col < 5'd3) seen[win_col] = win_data;
      if (win_col == 5'd23 && win_data[24:20] != 5'h1f) bad23++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got row=%0d col=%0d data=%h, none expected",
                 win_row, win_col, win_data);
      end else begin
        e = exp_q.pop_front();
        if (win_row != e.row || win_col != e.col || win_data != e.data || frame_done != e.done) begin
          errors++;
          $display("FAIL window got r=%0d c=%0d d=%h done=%0b, want r=%0d c=%0d d=%h done=%0b",
                   win_row, win_col, win_data, frame_done, e.row, e.col, e.data, e.done);
        end
      end
      if (win_col == 5'd0 && win_row != 5'd0) begin
        checks++;
        if (gap != 5) begin
          errors++;
          $display("FAIL row_gap got %0d idle cycles, want 5", gap);
        end
      end
      gap = 0;
    end else begin
      gap++;
      if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_vld got frame_done=1 win_vld=0, want 0");
      end
    end
    // Two consecutive cycles at the last address: the second is the row-end cycle.
    if (busy && data_rd_addr == 5'd27 && prev_addr == 5'd27) begin
      checks++;
      if (conv_row_cnt != prev_row) begin
        errors++;
        $display("FAIL row_end_hold got conv_row_cnt=%0d, want %0d", conv_row_cnt, prev_row);
      end
    end
    prev_addr = data_rd_addr;
    prev_row  = conv_row_cnt;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (data_rd_addr != 0 || conv_row_cnt != 0 || win_data != 0 || win_vld || win_row != 0 ||
        win_col != 0 || busy || frame_done) begin
      errors++;
      $display("FAIL %s got addr=%0d row=%0d data=%h vld=%0b wr=%0d wc=%0d busy=%0b done=%0b, want all 0",
               name, data_rd_addr, conv_row_cnt, win_data, win_vld, win_row, win_col, busy,
               frame_done);
    end
  endtask

  task automatic pulse_start();
    cal_start = 1'b1;
    @(posedge sclk); #1;
    cal_start = 1'b0;
  endtask

  // Returns #1 after the edge that raises frame_done.
  task automatic wait_done(input string name);
    int n = 0;
    while (!frame_done && n < 20000) begin
      @(posedge sclk); #1;
      n++;
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no frame_done in %0d cycles, want frame_done", name, n);
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = 1'b0;
  endtask

  task automatic checker_img();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = bit'((r + c) & 1);
  endtask

  initial begin
    int n;
    int cyc;
    int vld_at_rst;
    s_rst = 1'b1;
    cal_start = 1'b0;
    clear_img();
    repeat (3) @(posedge sclk);
    #1 s_rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(posedge sclk); #1;
      check_zero("idle_outputs");
    end

    // Single-pixel impulse at (0,0)
    img[0][0] = 1'b1;
    push_frame();
    vld_cnt = 0; done_cnt = 0;
    pulse_start();
    wait_done("impulse");
    @(posedge sclk); #1;
    check("impulse_busy_after_done", int'(busy), 0);
    check("impulse_windows", vld_cnt, 576);
    check("impulse_frame_done", done_cnt, 1);
    check("impulse_win00", int'(seen[0]), 32'h0000001);
    check("impulse_queue_empty", exp_q.size(), 0);

    // Checkerboard plus first-window latency
    checker_img();
    push_frame();
    vld_cnt = 0; done_cnt = 0;
    cal_start = 1'b1;
    @(posedge sclk); #1;
    cal_start = 1'b0;
    n = 0;
    while (!win_vld && n < 50) begin
      @(posedge sclk); #1;
      n++;
    end
    check("first_vld_latency", n, 6);
    wait_done("checker");
    @(posedge sclk); #1;
    check("checker_windows", vld_cnt, 576);
    check("checker_win00", int'(seen[0]), 32'h0AAAAAA);
    check("checker_win01", int'(seen[1]), 32'h1555555);
    check("checker_win02", int'(seen[2]), 32'h0AAAAAA);

    // Rightmost image column all ones
    clear_img();
    for (int r = 0; r < 28; r++) img[r][27] = 1'b1;
    push_frame();
    vld_cnt = 0; bad23 = 0;
    pulse_start();
    wait_done("col27");
    @(posedge sclk); #1;
    check("col27_windows", vld_cnt, 576);
    check("col27_right_edge_bad", bad23, 0);

    // Reset in the middle of a frame
    checker_img();
    push_frame();
    pulse_start();
    n = 0;
    while (!(win_vld && win_row == 5'd10 && win_col == 5'd7) && n < 5000) begin
      @(posedge sclk); #1;
      n++;
    end
    check("reach_win_10_7", int'(win_vld && win_row == 5'd10 && win_col == 5'd7), 1);
    s_rst = 1'b1;
    @(posedge sclk); #1;
    s_rst = 1'b0;
    check_zero("outputs_after_reset");
    vld_at_rst = vld_cnt;
    repeat (100) @(posedge sclk);
    #1;
    check("no_vld_after_reset", vld_cnt - vld_at_rst, 0);
    check_zero("idle_after_abort");
    exp_q.delete();
    push_frame();
    vld_cnt = 0; done_cnt = 0;
    pulse_start();
    wait_done("after_reset");
    @(posedge sclk); #1;
    check("after_reset_windows", vld_cnt, 576);
    check("after_reset_frame_done", done_cnt, 1);

    // cal_start pulses during a frame, then at and just after frame_done
    clear_img();
    img[5][9] = 1'b1; img[20][3] = 1'b1; img[27][27] = 1'b1;
    push_frame();
    vld_cnt = 0; done_cnt = 0;
    pulse_start();
    cyc = 0;
    while (!frame_done && cyc < 20000) begin
      cal_start = (cyc % 50 == 49) && (win_row < 5'd20);
      @(posedge sclk); #1;
      cyc++;
    end
    check("retrigger_reached_done", int'(frame_done), 1);
    cal_start = 1'b1;
    @(posedge sclk); #1;
    check("start_on_done_ignored", int'(busy), 0);
    check("retrigger_windows", vld_cnt, 576);
    check("retrigger_frame_done", done_cnt, 1);
    vld_cnt = 0; done_cnt = 0;
    push_frame();
    @(posedge sclk); #1;
    cal_start = 1'b0;
    check("start_after_done_accepted", int'(busy), 1);
    wait_done("second_frame");
    @(posedge sclk); #1;
    check("second_windows", vld_cnt, 576);
    check("second_frame_done", done_cnt, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got no completion, want $finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_window_rd.md
Name: conv_window_rd

Overview:
- Read-side controller for the 28x28 binary image buffer that the downsampler fills.
- On a frame-ready pulse, sweeps the buffer's read interface: 5-bit column address plus conv row select. The buffer returns a 5-bit vertical column slice, one read latency later.
- Assembles the slices into sliding 5x5 windows and streams them, with coordinates, to the convolution MAC: 24x24 = 576 windows per frame.

Parameters:
- IMG_W, 28, image columns (buffer address range 0..IMG_W-1); must be ≤32.
- IMG_H, 28, image rows; must be ≤32.
- K, 5, kernel size. Derived localparams: OUT_W = IMG_W-K+1 (24), OUT_H = IMG_H-K+1 (24).

Ports:
- sclk, input, 1, system clock.
- s_rst, input, 1, synchronous active-high reset.
- cal_start, input, 1, one-cycle pulse: image buffer is complete and a frame may be read.
- data_rd_addr, output, 5, buffer read column address.
- conv_row_cnt, output, 5, buffer row select: top image row of the current window row.
- col_data, input, 5, buffer slice. Bit r = image row conv_row_cnt+r at the address issued the previous cycle. Combinational from the current conv_row_cnt.
- win_data, output, 25, 5x5 window. Bit 5*c+r = image(row conv_row_cnt+r, col win_col+c); c=0 is the leftmost column.
- win_vld, output, 1, win_data / win_row / win_col valid this cycle.
- win_row, output, 5, output-map row 0..OUT_H-1.
- win_col, output, 5, output-map column 0..OUT_W-1.
- busy, output, 1, frame read in progress.
- frame_done, output, 1, one-cycle pulse on the last window of the frame.

Behaviour:
- Reset values (any cycle s_rst=1): state IDLE; data_rd_addr=0, conv_row_cnt=0, win_data=0, win_vld=0, win_row=0, win_col=0, busy=0, frame_done=0; shift register and read-valid pipe cleared.
- Reset mid-frame aborts the frame. No further win_vld until a new cal_start.
- Buffer read latency is fixed at 1 cycle: address issued in cycle t, slice on col_data in cycle t+1.
- State IDLE:
  - cal_start=1 → RUN next cycle, with data_rd_addr=0, conv_row_cnt=0, busy=1.
  - cal_start while busy=1 is ignored.
- State RUN (one address issued per cycle):
  - data_rd_addr < IMG_W-1 → data_rd_addr+1.
  - data_rd_addr = IMG_W-1 → ROW_END, with data_rd_addr held.
- State ROW_END (exactly one cycle):
  - conv_row_cnt is held so the column IMG_W-1 slice is still muxed with the correct row.
  - conv_row_cnt < OUT_H-1 → RUN, conv_row_cnt+1, data_rd_addr=0.
  - Otherwise → DRAIN.
- State DRAIN:
  - Waits for the final window to be emitted, then → IDLE, busy=0.
- Row timing: IMG_W+1 cycles per row (29). First address to last address of the frame: OUT_H*(IMG_W+1)-2 cycles.
- Capture pipeline:
  - rd_vld_d1 = registered (state==RUN); rd_col_d1 = registered data_rd_addr.
  - When rd_vld_d1=1, col_data shifts into the 5-column register: new column enters at c=4, oldest drops from c=0.
  - The shift register is cleared when column 0 of a row is captured, before the shift.
- Output register (registered, one cycle after capture):
  - Asserted when the capture had rd_col_d1 ≥ K-1.
  - win_data = shifted register; win_col = rd_col_d1-(K-1); win_row = conv_row_cnt value used for that capture.
  - Window latency: address a issued in cycle t → window with win_col=a-4 at t+2.
- Window output: win_vld is high for OUT_W consecutive cycles per row, then low for K cycles, i.e. the first 4 columns of the next row plus the ROW_END bubble.
  - No backpressure; the consumer must accept every window.
- frame_done: asserted with win_vld on win_row=OUT_H-1, win_col=OUT_W-1. busy drops to 0 the cycle after.
- cal_start coincident with frame_done is ignored. cal_start one cycle later is accepted.
- Widths: counters 5 bits unsigned. No wrap occurs because IMG_W ≤ 32.

Test Plan:
- Reset, then idle 10 cycles with cal_start=0 → all outputs 0, data_rd_addr stays 0.
- Image with pixel(r,c)=1 only at (0,0); one cal_start → exactly 576 win_vld pulses.
  - Only window (row0,col0) has win_data=25'h0000001; all others 0.
  - frame_done coincides with (23,23).
- Checkerboard image (pixel=(r+c)&1) → window (0,0) win_data bits follow (r+c)&1.
  - Windows at win_col 1 and 2 are bitwise inverses.
  - First win_vld 6 cycles after cal_start (RUN starts t+1, addr 4 at t+5, window at t+6).
- Row boundary: set image column 27 to all ones → window (r,23) has bits 20..24 = 1 for every r.
  - win_vld gap between rows is exactly 5 cycles.
  - conv_row_cnt is unchanged in the ROW_END cycle.
- Assert s_rst at window (10,7) for 1 cycle → outputs 0 next cycle, no further win_vld.
  - A new cal_start then yields a full 576-window frame starting at (0,0).
- cal_start pulsed every 50 cycles during a frame → ignored, 576 windows, one frame_done.
  - cal_start on the frame_done cycle is ignored; cal_start on the next cycle starts a second frame.
